halt_dump_sequencer: RTL and testbench

Synthesizable post-halt state dump engine for the pipelined CPU. It watches the CPU `halt` output and waits a configurable drain interval so in-flight pipeline writes retire. It then streams out, in order, the register-file contents and a window of data memory over a valid/ready port. It replaces the simulation-only `$writememh` dump sequence so the same dump works on silicon/FPGA, and supports a manual-trigger mode for repeated snapshots.

---
 rtl/halt_dump_sequencer.sv | 141 ++++++++++++++
 tb/tb_halt_dump_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/halt_dump_sequencer.sv
// halt_dump_sequencer: after a CPU halt (or manual trigger) and a drain interval,
// streams register-file words then a DMEM window over a valid/ready port.
module halt_dump_sequencer #(
    parameter int DATA_W       = 32,
    parameter int RF_DEPTH     = 32,
    parameter int MEM_BASE     = 0,
    parameter int MEM_WORDS    = 1024,
    parameter int ADDR_W       = 16,
    parameter int DRAIN_CYCLES = 16,
    parameter int TRIG_MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              trig,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_region,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int MAXD = (RF_DEPTH > MEM_WORDS) ? RF_DEPTH : MEM_WORDS;
    localparam int IW = $clog2(MAXD + 1);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IW-1:0] RF_LAST = IW'(RF_DEPTH - 1);
    localparam logic [IW-1:0] MEM_LAST = IW'((MEM_WORDS > 0) ? MEM_WORDS - 1 : 0);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, DRAIN, ISSUE, CAPT, HOLD, DONE} state_t;
    localparam state_t START = (DRAIN_CYCLES == 0) ? ISSUE : DRAIN;

    state_t            state_q, state_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              region_q, region_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_region_q, out_region_d;
    logic              out_last_q, out_last_d;
    logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic              trig_hit;

    assign trig_hit = (TRIG_MODE != 0) ? trig : halt;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        region_d     = region_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_region_d = out_region_q;
        out_last_d   = out_last_q;
        case (state_q)
            IDLE: if (trig_hit) begin
                state_d  = START;
                cnt_d    = '0;
                idx_d    = '0;
                region_d = 1'b0;
            end
            DRAIN: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DRAIN_LAST) state_d = ISSUE;
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                out_data_d   = region_q ? mem_rdata : rf_rdata;
                out_valid_d  = 1'b1;
                out_region_d = region_q;
                out_last_d   = region_q ? (idx_q == MEM_LAST) : (MEM_WORDS == 0 && idx_q == RF_LAST);
                state_d      = HOLD;
            end
            HOLD: if (out_ready) begin
                out_valid_d = 1'b0;
                if (out_last_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    if (!region_q && idx_q == RF_LAST) begin
                        region_d = 1'b1;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: if (TRIG_MODE != 0 && trig) begin
                state_d  = START;
                cnt_d    = '0;
                idx_d    = '0;
                region_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Address registers load on entry to ISSUE so the read lands during CAPT.
        rf_raddr_d  = (state_d == ISSUE && !region_d) ? ADDR_W'(idx_d) : rf_raddr_q;
        mem_raddr_d = (state_d == ISSUE && region_d) ? ADDR_W'(MEM_BASE) + ADDR_W'(idx_d) : mem_raddr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            region_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_region_q <= 1'b0;
            out_last_q   <= 1'b0;
            rf_raddr_q   <= '0;
            mem_raddr_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            region_q     <= region_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_region_q <= out_region_d;
            out_last_q   <= out_last_d;
            rf_raddr_q   <= rf_raddr_d;
            mem_raddr_q  <= mem_raddr_d;
        end
    end

    assign rf_raddr   = rf_raddr_q;
    assign mem_raddr  = mem_raddr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_region = out_region_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_halt_dump_sequencer.sv
// tb_halt_dump_sequencer: directed checks of three dump configurations
// (defaults, no-drain trig mode with RF only, offset DMEM window with random stalls).
module tb_halt_dump_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {last, region, data} of dump word w
    function automatic logic [33:0] exp_word(int w, int rfd, int base, int mw);
        logic [31:0] d;
        d = (w < rfd) ? 32'(w * 17) : 32'hA000_0000 + 32'(base + w - rfd);
        return {w == rfd + mw - 1, w >= rfd, d};
    endfunction

    logic        halt_a, trig_a, ready_a, valid_a, region_a, last_a, busy_a, done_a;
    logic [15:0] rf_ra_a, mem_ra_a;
    logic [31:0] rf_rd_a, mem_rd_a, data_a;
    logic        trig_b, ready_b, valid_b, region_b, last_b, busy_b, done_b;
    logic [15:0] rf_ra_b, mem_ra_b;
    logic [31:0] rf_rd_b, mem_rd_b, data_b;
    logic        halt_c, trig_c, ready_c, valid_c, region_c, last_c, busy_c, done_c;
    logic [15:0] rf_ra_c, mem_ra_c;
    logic [31:0] rf_rd_c, mem_rd_c, data_c;

    always @(posedge clk) begin
        rf_rd_a  <= 32'(rf_ra_a) * 32'h11;
        mem_rd_a <= 32'hA000_0000 + 32'(mem_ra_a);
        rf_rd_b  <= 32'(rf_ra_b) * 32'h11;
        mem_rd_b <= 32'hA000_0000 + 32'(mem_ra_b);
        rf_rd_c  <= 32'(rf_ra_c) * 32'h11;
        mem_rd_c <= 32'hA000_0000 + 32'(mem_ra_c);
    end

    halt_dump_sequencer dut_a (
        .clk(clk), .rst(rst), .halt(halt_a), .trig(trig_a),
        .rf_raddr(rf_ra_a), .rf_rdata(rf_rd_a), .mem_raddr(mem_ra_a), .mem_rdata(mem_rd_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_region(region_a),
        .out_last(last_a), .busy(busy_a), .done(done_a)
    );

    halt_dump_sequencer #(.RF_DEPTH(4), .MEM_WORDS(0), .DRAIN_CYCLES(0), .TRIG_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .halt(halt_a), .trig(trig_b),
        .rf_raddr(rf_ra_b), .rf_rdata(rf_rd_b), .mem_raddr(mem_ra_b), .mem_rdata(mem_rd_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_region(region_b),
        .out_last(last_b), .busy(busy_b), .done(done_b)
    );

    halt_dump_sequencer #(.RF_DEPTH(4), .MEM_BASE(256), .MEM_WORDS(8)) dut_c (
        .clk(clk), .rst(rst), .halt(halt_c), .trig(trig_c),
        .rf_raddr(rf_ra_c), .rf_rdata(rf_rd_c), .mem_raddr(mem_ra_c), .mem_rdata(mem_rd_c),
        .out_valid(valid_c), .out_ready(ready_c), .out_data(data_c), .out_region(region_c),
        .out_last(last_c), .busy(busy_c), .done(done_c)
    );

    // One trig-mode dump of dut_b with a stray trig pulse mid-stream.
    task automatic run_b(string tag);
        int w = 0, first_v = -1, done_k = -1;
        for (int k = 0; k < 200 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            trig_b = (k == 5);
            if (valid_b && first_v < 0) first_v = k;
            if (valid_b && ready_b) begin
                check({tag, "_word"}, {last_b, region_b, data_b}, exp_word(w, 4, 0, 0));
                w++;
            end
            if (done_b) done_k = k;
        end
        check({tag, "_first_valid"}, first_v, 2);
        check({tag, "_words"}, w, 4);
        check({tag, "_done_cycle"}, done_k, 12);
    endtask

    initial begin
        int w, first_v, done_k;
        logic [33:0] prev;
        logic prev_v, prev_r;
        halt_a = 0; trig_a = 0; ready_a = 1;
        trig_b = 0; ready_b = 1;
        halt_c = 0; trig_c = 0; ready_c = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_outputs", {valid_a, last_a, region_a, busy_a, done_a}, 5'b0);
        check("rst_data", data_a, 32'h0);
        check("rst_addr", {rf_ra_a, mem_ra_a}, 32'h0);

        // Full default dump, one-cycle halt pulse.
        repeat (7) @(posedge clk);
        #1 halt_a = 1;
        @(posedge clk);
        #1 halt_a = 0;
        check("A_busy_after_trig", busy_a, 1);
        w = 0; first_v = -1; done_k = -1;
        for (int k = 0; k < 4000 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (valid_a && first_v < 0) first_v = k;
            if (valid_a && ready_a) begin
                check("A_word", {last_a, region_a, data_a}, exp_word(w, 32, 0, 1024));
                w++;
            end
            if (done_a) done_k = k;
        end
        check("A_first_valid", first_v, 18);
        check("A_words", w, 1056);
        check("A_done_cycle", done_k, 3184);
        check("A_busy_at_done", busy_a, 0);
        check("B_halt_ignored", {busy_b, valid_b, done_b}, 3'b0);

        // Second halt after done must not start a new dump.
        halt_a = 1;
        repeat (3) @(posedge clk);
        #1 halt_a = 0;
        repeat (5) @(posedge clk);
        #1 check("A_no_retrigger", {busy_a, done_a, valid_a}, 3'b010);

        // Reset while holding word 20.
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        halt_a = 1;
        @(posedge clk);
        #1 halt_a = 0;
        for (int k = 0; k < 200 && !(valid_a && data_a == 32'h154); k++) begin
            @(posedge clk);
            #1;
        end
        ready_a = 0;
        check("A_w20_reached", {valid_a, data_a}, {1'b1, 32'h154});
        repeat (2) @(posedge clk);
        #1 check("A_w20_stall", {valid_a, region_a, last_a, data_a}, {3'b100, 32'h154});
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        check("A_midrst_outputs", {valid_a, last_a, region_a, busy_a, done_a}, 5'b0);
        check("A_midrst_data", data_a, 32'h0);
        check("A_midrst_addr", {rf_ra_a, mem_ra_a}, 32'h0);
        ready_a = 1;
        halt_a = 1;
        w = 0;
        for (int k = 0; k < 100 && w < 3; k++) begin
            @(posedge clk);
            #1 halt_a = 0;
            if (valid_a && ready_a) begin
                check("A_restart_word", {last_a, region_a, data_a}, exp_word(w, 32, 0, 1024));
                w++;
            end
        end
        check("A_restart_words", w, 3);

        // Trig mode: two identical dumps, mid-dump trig ignored.
        trig_b = 1;
        @(posedge clk);
        #1 trig_b = 0;
        check("B1_busy", busy_b, 1);
        run_b("B1");
        repeat (4) @(posedge clk);
        #1 check("B_idle_done", {done_b, busy_b}, 2'b10);
        trig_b = 1;
        @(posedge clk);
        #1 trig_b = 0;
        check("B2_restart", {done_b, busy_b}, 2'b01);
        run_b("B2");

        // Offset DMEM window under random backpressure.
        halt_c = 1;
        @(posedge clk);
        #1 halt_c = 0;
        w = 0; done_k = -1; prev_v = 0; prev_r = 0; prev = '0;
        for (int k = 0; k < 3000 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            ready_c = ($urandom_range(0, 9) < 3);
            if (prev_v && !prev_r)
                check("C_stall_stable", {valid_c, last_c, region_c, data_c}, {1'b1, prev});
            if (valid_c && ready_c) begin
                check("C_word", {last_c, region_c, data_c}, exp_word(w, 4, 256, 8));
                w++;
            end
            prev_v = valid_c; prev_r = ready_c; prev = {last_c, region_c, data_c};
            if (done_c) done_k = k;
        end
        check("C_words", w, 12);
        check("C_done_seen", done_k >= 0, 1);
        check("C_last_addr", mem_ra_c, 16'h107);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
